// File: rtl/PixelSensorConfig.sv
// Shared sensor configuration: array geometry, bus word types and the
// serializer state encoding used by the pixel stream receiver.
package PixelSensorConfig;

    localparam int PIXEL_ARRAY_WIDTH  = 4;
    localparam int PIXEL_ARRAY_HEIGHT = 4;
    localparam int OUTPUT_BUS_WIDTH   = 2;
    localparam int SENSOR_PIXEL_BITS  = 8;
    localparam int WORD_FIFO_DEPTH    = 4;
    localparam int FRAME_COUNT_BITS   = 16;

    typedef logic [SENSOR_PIXEL_BITS-1:0] pixel_t;
    typedef pixel_t [OUTPUT_BUS_WIDTH-1:0] bus_word_t;

    typedef enum logic {
        SER_IDLE = 1'b0,
        SER_EMIT = 1'b1
    } ser_state_t;

    // Counter width that stays at least one bit wide for degenerate sizes
    function automatic int safeClog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pixel_word_fifo.sv
// Small synchronous FIFO of bus words. Pointers carry one extra wrap bit so
// full and empty are told apart without a separate occupancy counter.
// The read port is combinational from the head entry (show-ahead).
module pixel_word_fifo
    import PixelSensorConfig::*;
#(
    parameter type word_t = bus_word_t,
    parameter int  DEPTH  = WORD_FIFO_DEPTH
) (
    input  logic  i_clk,
    input  logic  i_reset,
    input  logic  i_push,
    input  word_t i_wdata,
    input  logic  i_pop,
    output word_t o_rdata,
    output logic  o_full,
    output logic  o_empty
);

    localparam int ADDR_BITS = $clog2(DEPTH);

    word_t                r_mem [DEPTH];
    logic [ADDR_BITS:0]   r_wrPtr;
    logic [ADDR_BITS:0]   r_rdPtr;
    logic [ADDR_BITS-1:0] w_wrAddr;
    logic [ADDR_BITS-1:0] w_rdAddr;

    assign w_wrAddr = r_wrPtr[ADDR_BITS-1:0];
    assign w_rdAddr = r_rdPtr[ADDR_BITS-1:0];
    assign o_empty  = (r_wrPtr == r_rdPtr);
    assign o_full   = ({~r_wrPtr[ADDR_BITS], r_wrPtr[ADDR_BITS-1:0]} == r_rdPtr);
    assign o_rdata  = r_mem[w_rdAddr];

    // Storage array; contents need no reset because the pointers gate visibility
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[w_wrAddr] <= i_wdata;
        end
    end

    // Pointer update; push and pop may both fire in one cycle, even when full
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (i_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (i_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pixel_stream_receiver.sv
// Receives bus words from the sensor output buffer, synchronizes the word
// strobe into the local clock, buffers words in a FIFO and serializes them
// into a one-pixel-per-beat valid/ready stream tagged with raster position.
module pixel_stream_receiver
    import PixelSensorConfig::*;
#(
    parameter int ARRAY_WIDTH  = PIXEL_ARRAY_WIDTH,
    parameter int ARRAY_HEIGHT = PIXEL_ARRAY_HEIGHT,
    parameter int BUS_WIDTH    = OUTPUT_BUS_WIDTH,
    parameter int PIXEL_BITS   = SENSOR_PIXEL_BITS,
    parameter int FIFO_DEPTH   = WORD_FIFO_DEPTH
) (
    input  logic                                i_clk,
    input  logic                                i_reset,
    input  logic                                i_strobe_in,
    input  logic [BUS_WIDTH*PIXEL_BITS-1:0]     i_data_in,
    input  logic                                i_pix_ready,
    output logic                                o_pix_valid,
    output logic [PIXEL_BITS-1:0]               o_pixel_out,
    output logic [safeClog2(ARRAY_HEIGHT)-1:0]  o_pix_row,
    output logic [safeClog2(ARRAY_WIDTH)-1:0]   o_pix_col,
    output logic                                o_sof,
    output logic                                o_eol,
    output logic                                o_eof,
    output logic                                o_overflow,
    output logic [FRAME_COUNT_BITS-1:0]         o_frame_count
);

    localparam int ROW_BITS  = safeClog2(ARRAY_HEIGHT);
    localparam int COL_BITS  = safeClog2(ARRAY_WIDTH);
    localparam int LANE_BITS = safeClog2(BUS_WIDTH);

    typedef logic [PIXEL_BITS-1:0]      lanePixel_t;
    typedef lanePixel_t [BUS_WIDTH-1:0] laneWord_t;

    if (ARRAY_WIDTH % BUS_WIDTH != 0) begin : g_badBusWidth
        $error("ARRAY_WIDTH must be a multiple of BUS_WIDTH");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_badFifoDepth
        $error("FIFO_DEPTH must be a power of two and at least 2");
    end

    logic                  r_strobeSync1;
    logic                  r_strobeSync2;
    logic                  r_strobeSync3;
    logic                  w_capture;
    logic                  r_capValid;
    laneWord_t             r_capWord;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_drop;
    logic                  w_load;
    logic                  w_fifoFull;
    logic                  w_fifoEmpty;
    laneWord_t             w_fifoRdata;

    ser_state_t            r_state;
    ser_state_t            w_nextState;
    laneWord_t             r_word;
    logic [LANE_BITS-1:0]  r_lane;
    logic                  w_lastLane;
    logic                  w_beat;

    logic [COL_BITS-1:0]   r_col;
    logic [ROW_BITS-1:0]   r_row;
    logic                  w_colLast;
    logic                  w_rowLast;
    logic                  r_overflow;
    logic [FRAME_COUNT_BITS-1:0] r_frameCount;

    // Two-flop synchronizer plus an edge flop for the asynchronous word strobe
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_strobeSync1 <= 1'b0;
            r_strobeSync2 <= 1'b0;
            r_strobeSync3 <= 1'b0;
        end else begin
            r_strobeSync1 <= i_strobe_in;
            r_strobeSync2 <= r_strobeSync1;
            r_strobeSync3 <= r_strobeSync2;
        end
    end

    assign w_capture = r_strobeSync2 & ~r_strobeSync3;

    // Capture the bus word once per strobe edge; the sensor holds it long enough
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_capValid <= 1'b0;
            r_capWord  <= '0;
        end else begin
            r_capValid <= w_capture;
            if (w_capture) begin
                r_capWord <= laneWord_t'(i_data_in);
            end
        end
    end

    // A full FIFO still takes the word when the serializer pops in the same cycle
    assign w_push = r_capValid & (~w_fifoFull | w_pop);
    assign w_drop = r_capValid & w_fifoFull & ~w_pop;

    pixel_word_fifo #(
        .word_t (laneWord_t),
        .DEPTH  (FIFO_DEPTH)
    ) u_wordFifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_push),
        .i_wdata (r_capWord),
        .i_pop   (w_pop),
        .o_rdata (w_fifoRdata),
        .o_full  (w_fifoFull),
        .o_empty (w_fifoEmpty)
    );

    assign o_pix_valid = (r_state == SER_EMIT);
    assign w_beat      = o_pix_valid & i_pix_ready;
    assign w_lastLane  = (r_lane == LANE_BITS'(BUS_WIDTH - 1));

    // Serializer state register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= SER_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Serializer next state: fetch a word when idle, chain words without a bubble
    always_comb begin
        w_nextState = r_state;
        w_pop       = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            SER_IDLE: begin
                if (!w_fifoEmpty) begin
                    w_pop       = 1'b1;
                    w_load      = 1'b1;
                    w_nextState = SER_EMIT;
                end
            end
            SER_EMIT: begin
                if (w_beat && w_lastLane) begin
                    if (!w_fifoEmpty) begin
                        w_pop  = 1'b1;
                        w_load = 1'b1;
                    end else begin
                        w_nextState = SER_IDLE;
                    end
                end
            end
            default: begin
                w_nextState = SER_IDLE;
            end
        endcase
    end

    // Word register and lane index; both hold while the consumer stalls
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_word <= '0;
            r_lane <= '0;
        end else if (w_load) begin
            r_word <= w_fifoRdata;
            r_lane <= '0;
        end else if (w_beat) begin
            r_lane <= w_lastLane ? '0 : r_lane + 1'b1;
        end
    end

    assign w_colLast = (r_col == COL_BITS'(ARRAY_WIDTH - 1));
    assign w_rowLast = (r_row == ROW_BITS'(ARRAY_HEIGHT - 1));

    // Raster position of the pixel currently presented, advanced on each beat
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_beat) begin
            if (w_colLast) begin
                r_col <= '0;
                r_row <= w_rowLast ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Frame counter bumps on the last pixel of a frame; overflow is sticky
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_frameCount <= '0;
            r_overflow   <= 1'b0;
        end else begin
            if (w_beat && w_colLast && w_rowLast) begin
                r_frameCount <= r_frameCount + 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_pixel_out   = r_word[r_lane];
    assign o_pix_row     = r_row;
    assign o_pix_col     = r_col;
    assign o_sof         = o_pix_valid & (r_col == '0) & (r_row == '0);
    assign o_eol         = o_pix_valid & w_colLast;
    assign o_eof         = o_pix_valid & w_colLast & w_rowLast;
    assign o_overflow    = r_overflow;
    assign o_frame_count = r_frameCount;

endmodule

// File: tb/tb_pixel_stream_receiver.sv
// Directed bench for pixel_stream_receiver using the default 4x4 geometry,
// two pixels per bus word and a four-word FIFO.
module tb_pixel_stream_receiver;

    logic        clk;
    logic        reset;
    logic        strobeIn;
    logic [15:0] dataIn;
    logic        pixReady;
    logic        pixValid;
    logic [7:0]  pixelOut;
    logic [1:0]  pixRow;
    logic [1:0]  pixCol;
    logic        sof;
    logic        eol;
    logic        eof;
    logic        overflow;
    logic [15:0] frameCount;

    int checks = 0;
    int errors = 0;

    logic [14:0] beatQ [$];
    logic        stabEn = 1'b0;
    logic        prevStall = 1'b0;
    logic [12:0] prevSnap = '0;
    logic [15:0] readyPattern = 16'b0110_1011_0010_1101;
    int          patIdx = 0;

    pixel_stream_receiver dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_strobe_in   (strobeIn),
        .i_data_in     (dataIn),
        .i_pix_ready   (pixReady),
        .o_pix_valid   (pixValid),
        .o_pixel_out   (pixelOut),
        .o_pix_row     (pixRow),
        .o_pix_col     (pixCol),
        .o_sof         (sof),
        .o_eol         (eol),
        .o_eof         (eof),
        .o_overflow    (overflow),
        .o_frame_count (frameCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Expected beat k of a stream starting at pixel value base in a 4x4 frame
    function automatic logic [14:0] expBeat(input logic [7:0] base, input int k);
        int p;
        logic [1:0] r;
        logic [1:0] c;
        p = k % 16;
        r = 2'(p / 4);
        c = 2'(p % 4);
        return {base + 8'(k), r, c, (p == 0), (c == 2'd3), (p == 15)};
    endfunction

    function automatic logic [15:0] makeWord(input logic [7:0] base, input int j);
        return {base + 8'(2 * j + 1), base + 8'(2 * j)};
    endfunction

    // Record every accepted beat; check that stalled outputs hold still
    always @(negedge clk) begin
        if (!reset && pixValid && pixReady) begin
            beatQ.push_back({pixelOut, pixRow, pixCol, sof, eol, eof});
        end
        if (stabEn && !reset) begin
            if (prevStall) begin
                checkOutput("holdStable", {19'd0, pixValid, pixelOut, pixRow, pixCol}, {19'd0, prevSnap});
            end
            prevStall = pixValid & ~pixReady;
            prevSnap  = {pixValid, pixelOut, pixRow, pixCol};
        end else begin
            prevStall = 1'b0;
        end
    end

    // One sensor word: strobe high for 4 cycles, low for 4, data held throughout
    task automatic applyStimulus(input logic [15:0] word, input int readyAt, input bit usePattern);
        dataIn   = word;
        strobeIn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (i == 3) strobeIn = 1'b0;
            if (i == readyAt) pixReady = 1'b1;
            if (usePattern) begin
                pixReady = readyPattern[patIdx];
                patIdx   = (patIdx + 1) % 16;
            end
        end
    endtask

    task automatic resetDut();
        reset = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        beatQ.delete();
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_valid"}, pixValid, 0);
        checkOutput({tag, "_pixel"}, pixelOut, 0);
        checkOutput({tag, "_row"}, pixRow, 0);
        checkOutput({tag, "_col"}, pixCol, 0);
        checkOutput({tag, "_sof"}, sof, 0);
        checkOutput({tag, "_eol"}, eol, 0);
        checkOutput({tag, "_eof"}, eof, 0);
        checkOutput({tag, "_overflow"}, overflow, 0);
        checkOutput({tag, "_frameCount"}, frameCount, 0);
    endtask

    task automatic waitBeats(input int n, input int maxCycles, input string tag);
        int c = 0;
        while (beatQ.size() < n && c < maxCycles) begin
            @(posedge clk);
            #1;
            c++;
        end
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        checkOutput({tag, "_beatCount"}, beatQ.size(), n);
    endtask

    task automatic checkBeats(input logic [7:0] base, input int n, input string tag);
        for (int k = 0; k < n && k < beatQ.size(); k++) begin
            checkOutput($sformatf("%s_beat%0d", tag, k), beatQ[k], expBeat(base, k));
        end
    endtask

    initial begin
        reset    = 1'b1;
        strobeIn = 1'b0;
        dataIn   = '0;
        pixReady = 1'b0;

        // Reset state
        resetDut();
        checkAllZero("reset");

        // Single word: exact latency and two beats
        $display("[TB] single word latency");
        pixReady = 1'b1;
        dataIn   = 16'h2211;
        strobeIn = 1'b1;
        for (int e = 0; e < 4; e++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("t1_noValid_e%0d", e), pixValid, 0);
        end
        strobeIn = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("t1_e4_valid", pixValid, 1);
        checkOutput("t1_e4_beat", {pixelOut, pixRow, pixCol, sof, eol, eof}, {8'h11, 2'd0, 2'd0, 3'b100});
        @(posedge clk);
        #1;
        checkOutput("t1_e5_valid", pixValid, 1);
        checkOutput("t1_e5_beat", {pixelOut, pixRow, pixCol, sof, eol, eof}, {8'h22, 2'd0, 2'd1, 3'b000});
        @(posedge clk);
        #1;
        checkOutput("t1_e6_idle", pixValid, 0);

        // Full frame in raster order
        $display("[TB] full frame");
        resetDut();
        pixReady = 1'b1;
        for (int j = 0; j < 8; j++) applyStimulus(makeWord(8'h30, j), -1, 1'b0);
        waitBeats(16, 40, "t2");
        checkBeats(8'h30, 16, "t2");
        checkOutput("t2_frameCount", frameCount, 1);
        checkOutput("t2_overflow", overflow, 0);

        // Overflow with a stalled consumer
        $display("[TB] overflow");
        resetDut();
        pixReady = 1'b0;
        for (int j = 0; j < 6; j++) applyStimulus(makeWord(8'h50, j), -1, 1'b0);
        checkOutput("t3_overflow", overflow, 1);
        checkOutput("t3_stallValid", pixValid, 1);
        checkOutput("t3_stallPixel", pixelOut, 8'h50);
        checkOutput("t3_noBeats", beatQ.size(), 0);
        pixReady = 1'b1;
        waitBeats(10, 30, "t3");
        checkBeats(8'h50, 10, "t3");
        checkOutput("t3_overflowSticky", overflow, 1);
        checkOutput("t3_frameCount", frameCount, 0);

        // Backpressure toggling during a frame
        $display("[TB] backpressure");
        resetDut();
        stabEn = 1'b1;
        for (int j = 0; j < 8; j++) applyStimulus(makeWord(8'h70, j), -1, 1'b1);
        pixReady = 1'b1;
        waitBeats(16, 40, "t4");
        stabEn = 1'b0;
        checkBeats(8'h70, 16, "t4");
        checkOutput("t4_frameCount", frameCount, 1);
        checkOutput("t4_overflow", overflow, 0);

        // Reset in mid-frame
        $display("[TB] mid-frame reset");
        resetDut();
        pixReady = 1'b0;
        applyStimulus(16'h9190, -1, 1'b0);
        applyStimulus(16'h9392, -1, 1'b0);
        pixReady = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        pixReady = 1'b0;
        reset    = 1'b1;
        checkOutput("t5_preBeats", beatQ.size(), 3);
        checkBeats(8'h90, 3, "t5pre");
        @(posedge clk);
        #1;
        checkAllZero("t5_reset");
        reset    = 1'b0;
        pixReady = 1'b1;
        beatQ.delete();
        applyStimulus(16'hA1A0, -1, 1'b0);
        waitBeats(2, 20, "t5");
        checkBeats(8'hA0, 2, "t5");
        checkOutput("t5_frameCount", frameCount, 0);

        // Two frames with push and pop together while the FIFO is full
        $display("[TB] full boundary push+pop");
        resetDut();
        pixReady = 1'b0;
        for (int j = 0; j < 16; j++) applyStimulus(makeWord(8'hB0, j), (j == 5) ? 1 : -1, 1'b0);
        waitBeats(32, 60, "t6");
        checkBeats(8'hB0, 32, "t6");
        checkOutput("t6_frameCount", frameCount, 2);
        checkOutput("t6_overflow", overflow, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
